// File: rtl/screen_sequencer.sv
// Screen sequencer: TITLE -> PLAY -> WIN/LOSE -> TITLE with frame-timed fades,
// shared screen-ROM addressing and the final registered RGB stage.
module screen_sequencer #(
    parameter int unsigned IMG_W            = 160,
    parameter int unsigned IMG_H            = 120,
    parameter int unsigned HOLD_FRAMES      = 180,
    parameter int unsigned FADE_STEP_FRAMES = 4
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        start_btn,
    input  logic        win_evt,
    input  logic        lose_evt,
    input  logic [3:0]  game_red,
    input  logic [3:0]  game_green,
    input  logic [3:0]  game_blue,
    input  logic [3:0]  img_red,
    input  logic [3:0]  img_green,
    input  logic [3:0]  img_blue,
    output logic [1:0]  screen_sel,
    output logic [14:0] rom_address,
    output logic        game_run,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int unsigned STEP_W = $clog2(FADE_STEP_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);

    localparam logic [2:0] ST_TITLE    = 3'd0;
    localparam logic [2:0] ST_PLAY     = 3'd1;
    localparam logic [2:0] ST_WIN      = 3'd2;
    localparam logic [2:0] ST_LOSE     = 3'd3;
    localparam logic [2:0] ST_FADE_OUT = 3'd4;
    localparam logic [2:0] ST_FADE_IN  = 3'd5;

    localparam logic [1:0] SEL_GAME  = 2'd0;
    localparam logic [1:0] SEL_TITLE = 2'd1;
    localparam logic [1:0] SEL_WIN   = 2'd2;
    localparam logic [1:0] SEL_LOSE  = 2'd3;

    logic [2:0]        state_q, state_d;
    logic [2:0]        target_q, target_d;
    logic [1:0]        screen_sel_q, screen_sel_d;
    logic [3:0]        level_q, level_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              start_q, start_d;
    logic              origin_q, origin_d;
    logic              game_run_q, game_run_d;
    logic [3:0]        red_q, red_d;
    logic [3:0]        green_q, green_d;
    logic [3:0]        blue_q, blue_d;

    logic              at_origin_c;
    logic              frame_tick_c;
    logic              start_rise_c;
    logic [1:0]        target_sel_c;

    // 640x480 raster stretched down onto the IMG_W x IMG_H source image
    logic [31:0] col_c, row_c;
    always_comb begin
        col_c       = (32'(DrawX) * IMG_W) / 32'd640;
        row_c       = (32'(DrawY) * IMG_H) / 32'd480;
        rom_address = 15'(col_c + row_c * IMG_W);
    end

    assign at_origin_c  = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign frame_tick_c = at_origin_c && !origin_q;
    assign start_rise_c = start_btn && !start_q;
    assign start_d      = start_btn;
    assign origin_d     = at_origin_c;

    always_comb begin
        case (target_q)
            ST_PLAY: target_sel_c = SEL_GAME;
            ST_WIN:  target_sel_c = SEL_WIN;
            ST_LOSE: target_sel_c = SEL_LOSE;
            default: target_sel_c = SEL_TITLE;
        endcase
    end

    // Next-state logic; counters only move on frame ticks
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        screen_sel_d = screen_sel_q;
        level_d      = level_q;
        hold_d       = hold_q;
        step_d       = step_q;
        case (state_q)
            ST_TITLE: begin
                if (start_rise_c) begin
                    state_d  = ST_FADE_OUT;
                    target_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (win_evt) begin
                    state_d  = ST_FADE_OUT;
                    target_d = ST_WIN;
                end else if (lose_evt) begin
                    state_d  = ST_FADE_OUT;
                    target_d = ST_LOSE;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (frame_tick_c) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d   = '0;
                        state_d  = ST_FADE_OUT;
                        target_d = ST_TITLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ST_FADE_OUT: begin
                if (frame_tick_c) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = level_q - 4'd1;
                        if (level_q == 4'd1) begin
                            screen_sel_d = target_sel_c;
                            state_d      = ST_FADE_IN;
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            ST_FADE_IN: begin
                if (frame_tick_c) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = level_q + 4'd1;
                        if (level_q == 4'd14) begin
                            state_d = target_q;
                            hold_d  = '0;
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            default: begin
                state_d      = ST_TITLE;
                screen_sel_d = SEL_TITLE;
                level_d      = 4'd15;
                hold_d       = '0;
                step_d       = '0;
            end
        endcase
        game_run_d = (state_d == ST_PLAY);
    end

    // Pixel path: scale by (level+1)/16, zero during blanking
    logic [3:0] src_r_c, src_g_c, src_b_c;
    logic [7:0] scale_c;
    always_comb begin
        src_r_c = (screen_sel_q == SEL_GAME) ? game_red   : img_red;
        src_g_c = (screen_sel_q == SEL_GAME) ? game_green : img_green;
        src_b_c = (screen_sel_q == SEL_GAME) ? game_blue  : img_blue;
        scale_c = 8'(level_q) + 8'd1;
        red_d   = 4'd0;
        green_d = 4'd0;
        blue_d  = 4'd0;
        if (blank) begin
            red_d   = 4'((8'(src_r_c) * scale_c) >> 4);
            green_d = 4'((8'(src_g_c) * scale_c) >> 4);
            blue_d  = 4'((8'(src_b_c) * scale_c) >> 4);
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_TITLE;
            target_q     <= ST_TITLE;
            screen_sel_q <= SEL_TITLE;
            level_q      <= 4'd15;
            hold_q       <= '0;
            step_q       <= '0;
            start_q      <= 1'b0;
            origin_q     <= 1'b0;
            game_run_q   <= 1'b0;
            red_q        <= 4'd0;
            green_q      <= 4'd0;
            blue_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            screen_sel_q <= screen_sel_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            step_q       <= step_d;
            start_q      <= start_d;
            origin_q     <= origin_d;
            game_run_q   <= game_run_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
        end
    end

    assign screen_sel = screen_sel_q;
    assign game_run   = game_run_q;
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer; frames are compressed to two cycles each
// by stepping DrawX/DrawY through (0,0) and back to (1,0).
module tb_screen_sequencer;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank, start_btn, win_evt, lose_evt;
    logic [3:0]  game_red, game_green, game_blue;
    logic [3:0]  img_red, img_green, img_blue;
    logic [1:0]  screen_sel;
    logic [14:0] rom_address;
    logic        game_run;
    logic [3:0]  red, green, blue;

    int checks = 0;
    int errors = 0;

    always #5 vga_clk = ~vga_clk;

    screen_sequencer dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .start_btn  (start_btn),
        .win_evt    (win_evt),
        .lose_evt   (lose_evt),
        .game_red   (game_red),
        .game_green (game_green),
        .game_blue  (game_blue),
        .img_red    (img_red),
        .img_green  (img_green),
        .img_blue   (img_blue),
        .screen_sel (screen_sel),
        .rom_address(rom_address),
        .game_run   (game_run),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    // One frame = one tick cycle at (0,0) followed by one cycle at (1,0)
    task automatic frames(input int n);
        repeat (n) begin
            DrawX = 10'd0; DrawY = 10'd0;
            cyc(1);
            DrawX = 10'd1; DrawY = 10'd0;
            cyc(1);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        DrawX = 10'd1; DrawY = 10'd0; blank = 1'b1;
        start_btn = 1'b0; win_evt = 1'b0; lose_evt = 1'b0;
        game_red = 4'd15; game_green = 4'd15; game_blue = 4'd15;
        img_red = 4'd15; img_green = 4'd15; img_blue = 4'd15;
        cyc(2);
        checks++; if (red !== 4'd0) begin errors++; $display("FAIL reset_red got %0d want 0", red); end
        checks++; if (screen_sel !== 2'd1) begin errors++; $display("FAIL reset_sel got %0d want 1", screen_sel); end
        checks++; if (game_run !== 1'b0) begin errors++; $display("FAIL reset_game_run got %0b want 0", game_run); end
        reset_n = 1'b1;
        cyc(1);
        checks++; if (red !== 4'd15) begin errors++; $display("FAIL title_full_level got %0d want 15", red); end
    endtask

    task automatic test_title_start;
        start_btn = 1'b1;
        cyc(1000);
        checks++; if (screen_sel !== 2'd1) begin errors++; $display("FAIL hold_start_sel got %0d want 1", screen_sel); end
        checks++; if (game_run !== 1'b0) begin errors++; $display("FAIL hold_start_run got %0b want 0", game_run); end
        frames(32);
        checks++; if (red !== 4'd7) begin errors++; $display("FAIL fade_out_level7 got %0d want 7", red); end
        img_red = 4'd15; img_green = 4'd8; img_blue = 4'd1;
        cyc(1);
        checks++; if ({red, green, blue} !== {4'd7, 4'd4, 4'd0})
            begin errors++; $display("FAIL fade_math got %0d/%0d/%0d want 7/4/0", red, green, blue); end
        blank = 1'b0;
        cyc(1);
        checks++; if ({red, green, blue} !== 12'h000)
            begin errors++; $display("FAIL blank_zero got %0d/%0d/%0d want 0/0/0", red, green, blue); end
        blank = 1'b1;
        img_red = 4'd15; img_green = 4'd15; img_blue = 4'd15;
        frames(27);
        checks++; if (screen_sel !== 2'd1) begin errors++; $display("FAIL frame59_sel got %0d want 1", screen_sel); end
        checks++; if (red !== 4'd1) begin errors++; $display("FAIL frame59_level got %0d want 1", red); end
        frames(1);
        checks++; if (screen_sel !== 2'd0) begin errors++; $display("FAIL frame60_sel got %0d want 0", screen_sel); end
        checks++; if (red !== 4'd0) begin errors++; $display("FAIL frame60_level got %0d want 0", red); end
        frames(59);
        checks++; if (red !== 4'd14) begin errors++; $display("FAIL frame119_level got %0d want 14", red); end
        checks++; if (game_run !== 1'b0) begin errors++; $display("FAIL frame119_run got %0b want 0", game_run); end
        frames(1);
        checks++; if (red !== 4'd15) begin errors++; $display("FAIL frame120_level got %0d want 15", red); end
        checks++; if (game_run !== 1'b1) begin errors++; $display("FAIL frame120_run got %0b want 1", game_run); end
        start_btn = 1'b0;
        cyc(2);
        start_btn = 1'b1;
        cyc(2);
        frames(10);
        checks++; if (screen_sel !== 2'd0) begin errors++; $display("FAIL play_repress_sel got %0d want 0", screen_sel); end
        checks++; if (game_run !== 1'b1) begin errors++; $display("FAIL play_repress_run got %0b want 1", game_run); end
        checks++; if (red !== 4'd15) begin errors++; $display("FAIL play_repress_level got %0d want 15", red); end
    endtask

    task automatic test_address;
        DrawX = 10'd639; DrawY = 10'd479; #1;
        checks++; if (rom_address !== 15'd19199) begin errors++; $display("FAIL addr_639_479 got %0d want 19199", rom_address); end
        DrawX = 10'd4; DrawY = 10'd4; #1;
        checks++; if (rom_address !== 15'd161) begin errors++; $display("FAIL addr_4_4 got %0d want 161", rom_address); end
        DrawX = 10'd320; DrawY = 10'd240; #1;
        checks++; if (rom_address !== 15'd9680) begin errors++; $display("FAIL addr_320_240 got %0d want 9680", rom_address); end
        DrawX = 10'd799; DrawY = 10'd524; #1;
        checks++; if (rom_address !== 15'd21159) begin errors++; $display("FAIL addr_799_524 got %0d want 21159", rom_address); end
        DrawX = 10'd1; DrawY = 10'd0;
        cyc(1);
    endtask

    // start_btn stays high throughout, so returning to TITLE must not restart
    task automatic test_simul_win;
        win_evt = 1'b1; lose_evt = 1'b1;
        cyc(1);
        win_evt = 1'b0; lose_evt = 1'b0;
        checks++; if (game_run !== 1'b0) begin errors++; $display("FAIL win_run_drop got %0b want 0", game_run); end
        checks++; if (screen_sel !== 2'd0) begin errors++; $display("FAIL win_sel_early got %0d want 0", screen_sel); end
        frames(60);
        checks++; if (screen_sel !== 2'd2) begin errors++; $display("FAIL win_priority_sel got %0d want 2", screen_sel); end
        frames(60);
        checks++; if (red !== 4'd15) begin errors++; $display("FAIL win_full_level got %0d want 15", red); end
        checks++; if (game_run !== 1'b0) begin errors++; $display("FAIL win_run got %0b want 0", game_run); end
        lose_evt = 1'b1;
        cyc(1);
        lose_evt = 1'b0;
        frames(179);
        checks++; if (screen_sel !== 2'd2) begin errors++; $display("FAIL hold179_sel got %0d want 2", screen_sel); end
        checks++; if (red !== 4'd15) begin errors++; $display("FAIL hold179_level got %0d want 15", red); end
        frames(5);
        checks++; if (red !== 4'd14) begin errors++; $display("FAIL hold_fade_level got %0d want 14", red); end
        checks++; if (screen_sel !== 2'd2) begin errors++; $display("FAIL hold_fade_sel got %0d want 2", screen_sel); end
        frames(56);
        checks++; if (screen_sel !== 2'd1) begin errors++; $display("FAIL back_title_sel got %0d want 1", screen_sel); end
        frames(60);
        checks++; if (red !== 4'd15) begin errors++; $display("FAIL back_title_level got %0d want 15", red); end
        frames(10);
        checks++; if (screen_sel !== 2'd1) begin errors++; $display("FAIL held_start_sel got %0d want 1", screen_sel); end
        checks++; if (red !== 4'd15) begin errors++; $display("FAIL held_start_level got %0d want 15", red); end
    endtask

    task automatic test_ignored;
        lose_evt = 1'b1;
        cyc(1);
        lose_evt = 1'b0;
        frames(5);
        checks++; if (screen_sel !== 2'd1) begin errors++; $display("FAIL title_lose_sel got %0d want 1", screen_sel); end
        checks++; if (red !== 4'd15) begin errors++; $display("FAIL title_lose_level got %0d want 15", red); end
        start_btn = 1'b0;
        cyc(1);
        start_btn = 1'b1;
        cyc(1);
        frames(62);
        checks++; if (screen_sel !== 2'd0) begin errors++; $display("FAIL fade_in_sel got %0d want 0", screen_sel); end
        checks++; if (red !== 4'd0) begin errors++; $display("FAIL fade_in_level got %0d want 0", red); end
        lose_evt = 1'b1;
        cyc(1);
        lose_evt = 1'b0;
        frames(58);
        checks++; if (game_run !== 1'b1) begin errors++; $display("FAIL fade_in_lose_run got %0b want 1", game_run); end
        checks++; if (screen_sel !== 2'd0) begin errors++; $display("FAIL fade_in_lose_sel got %0d want 0", screen_sel); end
    endtask

    task automatic test_reset_mid_fade;
        win_evt = 1'b1;
        cyc(1);
        win_evt = 1'b0;
        frames(10);
        checks++; if (red !== 4'd13) begin errors++; $display("FAIL mid_fade_level got %0d want 13", red); end
        @(posedge vga_clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (red !== 4'd0) begin errors++; $display("FAIL async_rst_red got %0d want 0", red); end
        checks++; if (screen_sel !== 2'd1) begin errors++; $display("FAIL async_rst_sel got %0d want 1", screen_sel); end
        checks++; if (game_run !== 1'b0) begin errors++; $display("FAIL async_rst_run got %0b want 0", game_run); end
        start_btn = 1'b0;
        cyc(1);
        #2 reset_n = 1'b1;
        cyc(1);
        checks++; if (red !== 4'd15) begin errors++; $display("FAIL post_rst_level got %0d want 15", red); end
        checks++; if (screen_sel !== 2'd1) begin errors++; $display("FAIL post_rst_sel got %0d want 1", screen_sel); end
    endtask

    initial begin
        test_reset();
        test_title_start();
        test_address();
        test_simul_win();
        test_ignored();
        test_reset_mid_fade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
